// File: rtl/tdm_mux4_pkg.sv
// Shared definitions for the four-channel TDM multiplexer: channel codes,
// channel count and the output-register FSM encoding.
package tdm_mux4_pkg;

    localparam int NUM_CH = 4;

    // Channel select codes, {a,b} as seen by the far-end demux.
    localparam logic [1:0] CH_A = 2'b00;
    localparam logic [1:0] CH_B = 2'b01;
    localparam logic [1:0] CH_C = 2'b10;
    localparam logic [1:0] CH_D = 2'b11;

    // Pointer value after reset, so that channel A is searched first.
    localparam logic [1:0] RESET_LAST = CH_D;

    // Output register occupancy.
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

endpackage

// File: rtl/tdm_mux4_rr_arbiter4.sv
// Combinational round-robin arbiter over four requests. The search starts
// at the channel after the last grant and wraps from 3 to 0, ending with
// the last granted channel itself.
module rr_arbiter4
    import tdm_mux4_pkg::*;
(
    input  logic [3:0] req,
    input  logic [1:0] last,
    output logic       grant_valid,
    output logic [1:0] grant_idx
);

    logic [1:0] cand;

    // Pick the first requesting channel in order last+1, last+2, last+3, last.
    always_comb begin
        // NOTE: every signal written here gets a default first, otherwise
        // paths that skip an assignment would infer a latch.
        grant_valid = 1'b0;
        grant_idx   = last;
        cand        = '0;
        for (int k = 1; k <= NUM_CH; k++) begin
            cand = last + 2'(k);
            if (!grant_valid && req[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/tdm_mux4.sv
// Four-channel round-robin time-division multiplexer. Each lane has a
// one-entry buffer; a registered output stage drains the buffers one word
// per clock, tagging each word with its channel code for the far-end demux.
module tdm_mux4
    import tdm_mux4_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [3:0]            in_valid,
    input  logic [4*WIDTH-1:0]    in_data,
    output logic [3:0]            in_ready,
    output logic                  out_valid,
    output logic [1:0]            out_sel,
    output logic [WIDTH-1:0]      out_data,
    input  logic                  out_ready
);

    state_t           state;
    logic [3:0]       buf_full;
    logic [WIDTH-1:0] buf_data [NUM_CH];
    logic [1:0]       last;

    logic             grant_valid;
    logic [1:0]       grant_idx;
    logic             advance;
    logic             take;

    // Buffers only accept while empty; a buffer granted this cycle is still
    // full, so it cannot be refilled on the edge that empties it.
    assign in_ready = ~buf_full;

    // The output register moves whenever it is empty or being consumed.
    assign advance  = (state == ST_EMPTY) | out_ready;
    assign take     = advance & grant_valid;

    rr_arbiter4 u_arb (
        .req         (buf_full),
        .last        (last),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    // Capture accepted words into the per-channel buffers.
    always_ff @(posedge clk) begin
        // NOTE: buf_data is not reset; buf_full alone says whether an entry
        // is meaningful, so clearing the data would only cost reset fan-out.
        for (int i = 0; i < NUM_CH; i++) begin
            if (in_valid[i] && !buf_full[i]) begin
                buf_data[i] <= in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Buffer occupancy: set on acceptance, cleared when granted.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            buf_full <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (take && (grant_idx == 2'(i))) begin
                    buf_full[i] <= 1'b0;
                end else if (in_valid[i] && !buf_full[i]) begin
                    buf_full[i] <= 1'b1;
                end
            end
        end
    end

    // Output register FSM with round-robin pointer update on each grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_EMPTY;
            out_valid <= 1'b0;
            out_sel   <= CH_A;
            out_data  <= '0;
            last      <= RESET_LAST;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (grant_valid) begin
                        state     <= ST_FULL;
                        out_valid <= 1'b1;
                        out_sel   <= grant_idx;
                        out_data  <= buf_data[grant_idx];
                        last      <= grant_idx;
                    end
                end
                ST_FULL: begin
                    if (out_ready) begin
                        if (grant_valid) begin
                            out_sel  <= grant_idx;
                            out_data <= buf_data[grant_idx];
                            last     <= grant_idx;
                        end else begin
                            state     <= ST_EMPTY;
                            out_valid <= 1'b0;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tdm_mux4.sv
// Directed bench for tdm_mux4: a vector table for reset-relative sequences
// plus hand-written fairness, mid-operation reset and loopback sequences.
module tb_tdm_mux4;

    localparam int W = 2;

    logic           clk;
    logic           rst;
    logic [3:0]     in_valid;
    logic [4*W-1:0] in_data;
    logic [3:0]     in_ready;
    logic           out_valid;
    logic [1:0]     out_sel;
    logic [W-1:0]   out_data;
    logic           out_ready;

    int n_checks = 0;
    int n_fail   = 0;

    tdm_mux4 #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_sel   (out_sel),
        .out_data  (out_data),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    typedef struct packed {
        logic [3:0]     in_valid;
        logic [4*W-1:0] in_data;
        logic           out_ready;
        logic [3:0]     exp_in_ready;
        logic           exp_out_valid;
        logic [1:0]     exp_sel;
        logic [W-1:0]   exp_data;
    } vec_t;

    localparam int NV = 19;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One rising edge, then return on the falling edge for sampling/driving.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    logic [1:0] exp_sel;
    logic [3:0] demux_out;
    bit         seen;

    initial begin
        // Simultaneous offers, data = channel index, drained 0,1,2,3.
        vecs[0]  = '{4'b1111, 8'b11_10_01_00, 1'b1, 4'b0000, 1'b0, 2'd0, 2'd0};
        vecs[1]  = '{4'b0000, 8'h00,          1'b1, 4'b0001, 1'b1, 2'd0, 2'd0};
        vecs[2]  = '{4'b0000, 8'h00,          1'b1, 4'b0011, 1'b1, 2'd1, 2'd1};
        vecs[3]  = '{4'b0000, 8'h00,          1'b1, 4'b0111, 1'b1, 2'd2, 2'd2};
        vecs[4]  = '{4'b0000, 8'h00,          1'b1, 4'b1111, 1'b1, 2'd3, 2'd3};
        vecs[5]  = '{4'b0000, 8'h00,          1'b1, 4'b1111, 1'b0, 2'd3, 2'd3};
        // Single word on channel 2, data 1: visible after the second edge.
        vecs[6]  = '{4'b0100, 8'b00_01_00_00, 1'b1, 4'b1011, 1'b0, 2'd3, 2'd3};
        vecs[7]  = '{4'b0000, 8'h00,          1'b1, 4'b1111, 1'b1, 2'd2, 2'd1};
        vecs[8]  = '{4'b0000, 8'h00,          1'b1, 4'b1111, 1'b0, 2'd2, 2'd1};
        // Backpressure: out_ready low for five edges.
        vecs[9]  = '{4'b0001, 8'b00_00_00_10, 1'b0, 4'b1110, 1'b0, 2'd2, 2'd1};
        vecs[10] = '{4'b0011, 8'b00_00_11_01, 1'b0, 4'b1101, 1'b1, 2'd0, 2'd2};
        vecs[11] = '{4'b1111, 8'b01_10_00_11, 1'b0, 4'b0000, 1'b1, 2'd0, 2'd2};
        vecs[12] = '{4'b0000, 8'h00,          1'b0, 4'b0000, 1'b1, 2'd0, 2'd2};
        vecs[13] = '{4'b0000, 8'h00,          1'b0, 4'b0000, 1'b1, 2'd0, 2'd2};
        // Release: drain 1,2,3,0 in round-robin order.
        vecs[14] = '{4'b0000, 8'h00,          1'b1, 4'b0010, 1'b1, 2'd1, 2'd3};
        vecs[15] = '{4'b0000, 8'h00,          1'b1, 4'b0110, 1'b1, 2'd2, 2'd2};
        vecs[16] = '{4'b0000, 8'h00,          1'b1, 4'b1110, 1'b1, 2'd3, 2'd1};
        vecs[17] = '{4'b0000, 8'h00,          1'b1, 4'b1111, 1'b1, 2'd0, 2'd3};
        vecs[18] = '{4'b0000, 8'h00,          1'b1, 4'b1111, 1'b0, 2'd0, 2'd3};

        rst       = 1'b1;
        in_valid  = '0;
        in_data   = '0;
        out_ready = 1'b1;
        @(negedge clk);
        step();
        step();
        rst = 1'b0;
        check("reset_in_ready",  in_ready,  4'b1111);
        check("reset_out_valid", out_valid, 1'b0);
        check("reset_out_sel",   out_sel,   2'b00);
        check("reset_out_data",  out_data,  '0);

        for (int v = 0; v < NV; v++) begin
            in_valid  = vecs[v].in_valid;
            in_data   = vecs[v].in_data;
            out_ready = vecs[v].out_ready;
            step();
            check($sformatf("vec%0d_in_ready", v),  in_ready,  vecs[v].exp_in_ready);
            check($sformatf("vec%0d_out_valid", v), out_valid, vecs[v].exp_out_valid);
            check($sformatf("vec%0d_out_sel", v),   out_sel,   vecs[v].exp_sel);
            check($sformatf("vec%0d_out_data", v),  out_data,  vecs[v].exp_data);
        end

        // Fairness: channels 0 and 3 request continuously, last = 0 here.
        in_valid  = 4'b1001;
        in_data   = 8'b10_00_00_01;
        out_ready = 1'b1;
        step();
        exp_sel = 2'd3;
        for (int c = 0; c < 10; c++) begin
            step();
            check($sformatf("fair%0d_valid", c), out_valid, 1'b1);
            check($sformatf("fair%0d_sel", c),   out_sel,   exp_sel);
            check($sformatf("fair%0d_data", c),  out_data,  (exp_sel == 2'd3) ? 2'd2 : 2'd1);
            exp_sel = (exp_sel == 2'd3) ? 2'd0 : 2'd3;
        end
        in_valid = '0;
        step();
        step();
        step();
        check("fair_drained_valid", out_valid, 1'b0);
        check("fair_drained_ready", in_ready,  4'b1111);

        // Reset mid-operation with one word on the output and 3 buffers full.
        in_valid  = 4'b1111;
        in_data   = 8'b11_10_01_00;
        out_ready = 1'b0;
        step();
        in_valid = '0;
        step();
        check("mid_out_valid", out_valid, 1'b1);
        check("mid_full_bufs", $countones(~in_ready), 3);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_in_ready",  in_ready,  4'b1111);
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_out_sel",   out_sel,   2'b00);
        check("midrst_out_data",  out_data,  '0);
        out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step();
            check($sformatf("midrst_stale%0d", c), out_valid, 1'b0);
        end
        // Pointer is back at 3, so channel 0 wins the first grant.
        in_valid = 4'b1111;
        in_data  = 8'b11_10_01_00;
        step();
        in_valid = '0;
        step();
        check("midrst_first_sel",  out_sel,   2'd0);
        check("midrst_first_data", out_data,  2'd0);
        for (int c = 0; c < 4; c++) step();
        check("midrst_drained", out_valid, 1'b0);

        // Loopback through a demux model: {a,b} = out_sel selects A..D.
        for (int i = 0; i < 4; i++) begin
            in_valid = 4'b0001 << i;
            in_data  = 8'b01 << (2 * i);
            step();
            in_valid = '0;
            seen = 1'b0;
            for (int c = 0; c < 4 && !seen; c++) begin
                step();
                if (out_valid) seen = 1'b1;
            end
            check($sformatf("loop%0d_arrived", i), seen, 1'b1);
            demux_out = out_valid ? (4'({3'b000, out_data[0]}) << out_sel) : 4'b0000;
            check($sformatf("loop%0d_demux", i), demux_out, 4'b0001 << i);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
